seven_seg_scan_decoder: RTL and testbench

Receive-side companion to the team's seven-segment driver: watches a time-multiplexed 4-digit segment/anode bus and recovers the hexadecimal digits being shown. For each digit it waits until the segment pattern has been stable long enough, decodes it, and stores it. When all four digits have been captured since the last report, it emits one 16-bit frame. It is used in self-checking display paths and in loopback benches behind the driver.

---
 rtl/seven_seg_scan_if.sv | 15 +
 rtl/seven_seg_scan_decoder.sv | 158 +++++++++++++++
 tb/tb_seven_seg_scan_decoder.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/seven_seg_scan_if.sv
// Segment/anode scan bus seen by the decoder, plus the recovered-frame outputs.
interface seven_seg_scan_if;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic [15:0] value;
  logic [3:0]  blank_mask;
  logic [3:0]  err_mask;
  logic        frame_valid;
  logic        bus_err;

  modport master (output seg, an,
                  input  value, blank_mask, err_mask, frame_valid, bus_err);
  modport slave  (input  seg, an,
                  output value, blank_mask, err_mask, frame_valid, bus_err);
endinterface

// File: rtl/seven_seg_scan_decoder.sv
// Recovers hex digits from a multiplexed 4-digit seven-segment bus and emits
// one 16-bit frame once every digit has been captured since the last report.
module seven_seg_scan_decoder #(
  parameter int STABLE_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst,
  seven_seg_scan_if.slave  bus
);
  localparam int          NUM_DIG   = 4;
  localparam logic [7:0]  STABLE_M1 = 8'(STABLE_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, SETTLE, HOLD} state_e;

  logic [10:0] sync1_q, sync2_q;
  logic [6:0]  seg_s;
  logic [3:0]  an_s;
  assign {an_s, seg_s} = sync2_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= {bus.an, bus.seg};
      sync2_q <= sync1_q;
    end
  end

  // {blank, err, nibble}
  function automatic logic [5:0] dec(input logic [6:0] s);
    case (s)
      7'h7E: dec = 6'h00;  7'h30: dec = 6'h01;  7'h6D: dec = 6'h02;  7'h79: dec = 6'h03;
      7'h33: dec = 6'h04;  7'h5B: dec = 6'h05;  7'h5F: dec = 6'h06;  7'h70: dec = 6'h07;
      7'h7F: dec = 6'h08;  7'h7B: dec = 6'h09;  7'h77: dec = 6'h0A;  7'h1F: dec = 6'h0B;
      7'h4E: dec = 6'h0C;  7'h3D: dec = 6'h0D;  7'h4F: dec = 6'h0E;  7'h47: dec = 6'h0F;
      7'h00: dec = 6'b10_0000;
      default: dec = 6'b01_0000;
    endcase
  endfunction

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [3:0]  ref_an_q, ref_an_d;
  logic [6:0]  ref_seg_q, ref_seg_d;
  logic        accept, an_multi, an_onehot, same;

  assign an_multi  = (an_s & (an_s - 4'd1)) != 4'd0;
  assign an_onehot = (an_s != 4'd0) && !an_multi;
  assign same      = (an_s == ref_an_q) && (seg_s == ref_seg_q);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ref_an_d  = ref_an_q;
    ref_seg_d = ref_seg_q;
    accept    = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (an_onehot) begin
          state_d = SETTLE; ref_an_d = an_s; ref_seg_d = seg_s; cnt_d = 8'd1;
        end
      end
      SETTLE: begin
        if (same) begin
          cnt_d = cnt_q + 8'd1;
          if (cnt_q == STABLE_M1) begin
            accept  = 1'b1;
            state_d = HOLD;
          end
        end else if (an_onehot) begin
          ref_an_d = an_s; ref_seg_d = seg_s; cnt_d = 8'd1;
        end else begin
          state_d = IDLE; cnt_d = '0;
        end
      end
      HOLD: begin
        // an unchanged digit is never accepted twice
        if (!same) begin
          if (an_onehot) begin
            state_d = SETTLE; ref_an_d = an_s; ref_seg_d = seg_s; cnt_d = 8'd1;
          end else begin
            state_d = IDLE; cnt_d = '0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      ref_an_q  <= '0;
      ref_seg_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ref_an_q  <= ref_an_d;
      ref_seg_q <= ref_seg_d;
    end
  end

  logic [5:0]                    dec_r;
  logic [NUM_DIG-1:0]            wr;
  logic [NUM_DIG-1:0][3:0]       dig_q, dig_d;
  logic [NUM_DIG-1:0]            blank_q, blank_d, err_q, err_d, cap_q, cap_d;
  logic                          frame_done;
  logic [15:0]                   value_q;
  logic [3:0]                    blank_mask_q, err_mask_q;
  logic                          frame_valid_q, bus_err_q;

  assign dec_r = dec(ref_seg_q);

  for (genvar k = 0; k < NUM_DIG; k++) begin : g_dig
    assign wr[k]      = accept && ref_an_q[k];
    assign dig_d[k]   = wr[k] ? dec_r[3:0] : dig_q[k];
    assign blank_d[k] = wr[k] ? dec_r[5]   : blank_q[k];
    assign err_d[k]   = wr[k] ? dec_r[4]   : err_q[k];
  end

  assign cap_d      = cap_q | wr;
  assign frame_done = &cap_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dig_q         <= '0;
      blank_q       <= '0;
      err_q         <= '0;
      cap_q         <= '0;
      value_q       <= '0;
      blank_mask_q  <= '0;
      err_mask_q    <= '0;
      frame_valid_q <= 1'b0;
      bus_err_q     <= 1'b0;
    end else begin
      dig_q         <= dig_d;
      blank_q       <= blank_d;
      err_q         <= err_d;
      cap_q         <= frame_done ? '0 : cap_d;
      frame_valid_q <= frame_done;
      if (frame_done) begin
        value_q      <= dig_d;
        blank_mask_q <= blank_d;
        err_mask_q   <= err_d;
      end
      if (an_multi) bus_err_q <= 1'b1;
    end
  end

  assign bus.value       = value_q;
  assign bus.blank_mask  = blank_mask_q;
  assign bus.err_mask    = err_mask_q;
  assign bus.frame_valid = frame_valid_q;
  assign bus.bus_err     = bus_err_q;
endmodule

// File: tb/tb_seven_seg_scan_decoder.sv
// Randomized and directed bench for seven_seg_scan_decoder against a run-length
// reference model of the synchronized scan stream.
module tb_seven_seg_scan_decoder;
  localparam int S = 4;
  localparam logic [6:0] PAT [0:15] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                                         7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};

  logic clk = 1'b0;
  logic rst = 1'b1;
  seven_seg_scan_if bus();

  seven_seg_scan_decoder #(.STABLE_CYCLES(S)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  int n_cmp = 0, n_mis = 0, fv_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    if (obs !== exp_v) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // reference model: synchronized stream = pins delayed two clocks; a digit is
  // accepted when a run of identical one-hot samples reaches length S
  logic [10:0] m_s1, m_s2, m_prev;
  int          m_run;
  logic [3:0]  m_dig [4];
  logic [3:0]  m_blk, m_err, m_cap;
  logic [15:0] e_value;
  logic [3:0]  e_blank, e_err;
  logic        e_fv, e_berr;

  task automatic m_reset();
    m_s1 = '0; m_s2 = '0; m_prev = '0; m_run = 0;
    for (int i = 0; i < 4; i++) m_dig[i] = '0;
    m_blk = '0; m_err = '0; m_cap = '0;
    e_value = '0; e_blank = '0; e_err = '0; e_fv = 1'b0; e_berr = 1'b0;
  endtask

  task automatic m_step();
    logic [3:0] a;
    logic [6:0] sg;
    int k;
    a  = m_s2[10:7];
    sg = m_s2[6:0];
    e_fv = 1'b0;
    if (m_s2 == m_prev) m_run++; else m_run = 1;
    m_prev = m_s2;
    if ($countones(a) > 1) e_berr = 1'b1;
    if ($countones(a) == 1 && m_run == S) begin
      k = 0;
      for (int i = 0; i < 4; i++) if (a[i]) k = i;
      m_dig[k] = 4'h0; m_blk[k] = (sg == 7'h00); m_err[k] = (sg != 7'h00);
      for (int p = 0; p < 16; p++) if (PAT[p] == sg) begin m_dig[k] = 4'(p); m_err[k] = 1'b0; end
      m_cap[k] = 1'b1;
      if (m_cap == 4'hF) begin
        e_value = {m_dig[3], m_dig[2], m_dig[1], m_dig[0]};
        e_blank = m_blk; e_err = m_err; e_fv = 1'b1; m_cap = '0;
      end
    end
    m_s2 = m_s1;
    m_s1 = {bus.an, bus.seg};
  endtask

  task automatic tick();
    @(posedge clk);
    m_step();
    #1;
    if (bus.frame_valid === 1'b1) fv_cnt++;
    chk("frame_valid", bus.frame_valid, e_fv);
    chk("value", bus.value, e_value);
    chk("blank_mask", bus.blank_mask, e_blank);
    chk("err_mask", bus.err_mask, e_err);
    chk("bus_err", bus.bus_err, e_berr);
  endtask

  task automatic drive(input logic [3:0] a, input logic [6:0] s, input int n);
    bus.an = a; bus.seg = s;
    repeat (n) tick();
  endtask

  task automatic do_reset();
    rst = 1'b1; bus.an = '0; bus.seg = '0;
    m_reset();
    #1;
    chk("rst_fv", bus.frame_valid, 0);
    chk("rst_value", bus.value, 0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_blank", bus.blank_mask, 0);
    chk("rst_err", bus.err_mask, 0);
    chk("rst_buserr", bus.bus_err, 0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic scan4(input logic [6:0] s0, s1, s2, s3, input int n);
    drive(4'h1, s0, n); drive(4'h2, s1, n); drive(4'h4, s2, n); drive(4'h8, s3, n);
  endtask

  initial begin
    bus.an = '0; bus.seg = '0;
    do_reset();

    // basic scan
    fv_cnt = 0;
    scan4(7'h30, 7'h6D, 7'h79, 7'h33, 10); drive(4'h0, 7'h00, 6);
    chk("s1_frames", fv_cnt, 1);
    chk("s1_value", bus.value, 16'h4321);
    chk("s1_masks", {bus.blank_mask, bus.err_mask}, 8'h00);

    // too-short holds give nothing, S-cycle holds give a frame
    fv_cnt = 0;
    scan4(7'h7E, 7'h30, 7'h6D, 7'h79, 3); scan4(7'h30, 7'h6D, 7'h79, 7'h33, 3);
    drive(4'h0, 7'h00, 6);
    chk("s2_noframe", fv_cnt, 0);
    scan4(7'h77, 7'h1F, 7'h4E, 7'h3D, 4); drive(4'h0, 7'h00, 6);
    chk("s2_frames", fv_cnt, 1);
    chk("s2_value", bus.value, 16'hDCBA);

    // blank and undecodable digits
    fv_cnt = 0;
    scan4(7'h01, 7'h7F, 7'h00, 7'h7F, 6); drive(4'h0, 7'h00, 6);
    chk("s3_value", bus.value, 16'h8080);
    chk("s3_blank", bus.blank_mask, 4'b0100);
    chk("s3_err", bus.err_mask, 4'b0001);

    // one-cycle multi-hot glitch mid-scan
    fv_cnt = 0;
    drive(4'h1, 7'h5B, 6); drive(4'h2, 7'h5F, 6); drive(4'h3, 7'h70, 1);
    drive(4'h4, 7'h7B, 6); drive(4'h8, 7'h47, 6); drive(4'h0, 7'h00, 6);
    chk("s4_buserr", bus.bus_err, 1);
    chk("s4_frames", fv_cnt, 1);
    chk("s4_value", bus.value, 16'hF965);

    // rescan of digit 1 before completion: newest wins
    fv_cnt = 0;
    drive(4'h1, 7'h7E, 6); drive(4'h2, 7'h30, 6); drive(4'h4, 7'h6D, 6);
    drive(4'h2, 7'h79, 6); drive(4'h8, 7'h33, 6); drive(4'h0, 7'h00, 6);
    chk("s5_frames", fv_cnt, 1);
    chk("s5_value", bus.value, 16'h4230);

    // reset with three digits captured discards the partial frame
    drive(4'h1, 7'h4F, 8); drive(4'h2, 7'h4F, 8); drive(4'h4, 7'h4F, 8);
    do_reset();
    fv_cnt = 0;
    scan4(7'h5B, 7'h70, 7'h7F, 7'h30, 8); drive(4'h0, 7'h00, 6);
    chk("s6_frames", fv_cnt, 1);
    chk("s6_value", bus.value, 16'h1875);
    chk("s6_buserr", bus.bus_err, 0);

    // randomized scanning
    for (int it = 0; it < 200; it++) begin
      int r, r2;
      logic [3:0] a;
      logic [6:0] s;
      r  = $urandom_range(0, 9);
      r2 = $urandom_range(0, 9);
      if (r < 8)       a = 4'(1 << $urandom_range(0, 3));
      else if (r == 8) a = 4'h0;
      else             a = 4'($urandom_range(0, 15));
      if (r2 < 8)       s = PAT[$urandom_range(0, 15)];
      else if (r2 == 8) s = 7'h00;
      else              s = 7'($urandom_range(0, 127));
      drive(a, s, $urandom_range(1, 9));
    end
    drive(4'h0, 7'h00, 6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
